// File: rtl/axi_error_reporter_mc_if.sv
// AXI4-Lite bus bundle for the multi-channel error reporter.
// The slave modport is the reporter side; master is the interconnect side.
interface axi_error_reporter_mc_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axi_error_reporter_mc.sv
// Multi-channel error reporter: per-channel first-error snapshot, saturating
// event counter, write-1-to-clear capture flags and a maskable level interrupt.
module axi_error_reporter_mc #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 512,
  parameter int ERR_W  = 9,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_eth_active,
  input  logic [NUM_CH-1:0]        ch_status,
  input  logic [NUM_CH*ERR_W-1:0]  ch_error,
  input  logic [NUM_CH*DATA_W-1:0] ch_error_data,
  input  logic [NUM_CH*32-1:0]     ch_expected_fdata,
  output logic                     irq,
  axi_error_reporter_mc_if.slave   s_axi
);
  localparam int NW = DATA_W / 32;
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [31:0] INFO = {8'(NW), 8'(ERR_W), 8'(NUM_CH), 8'h01};
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Per-channel state
  logic [NUM_CH-1:0]             prev_q, cap_q, cap_d, irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]             nz, ev, load, clr;
  logic [NUM_CH-1:0][31:0]       cnt_q, cnt_d, fd_q;
  logic [NUM_CH-1:0][ERR_W-1:0]  code_q;
  logic [NUM_CH-1:0][DATA_W-1:0] data_q;
  logic                          irq_q;

  // Write path state
  logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic             awready_q, wready_q, bvalid_q, bvalid_d;
  logic [1:0]       bresp_q;
  logic [IDX_W-1:0] widx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_hs, w_hs, b_hs, wr_commit, wr_clr, wr_ien, wr_ok;

  // Read path state
  logic        arready_q, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rd_data, ridx, rel;
  logic [1:0]  rresp_q;
  logic        rd_err, ar_hs, r_hs;
  int          rk;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

  assign aw_hs = s_axi.awvalid & awready_q;
  assign w_hs  = s_axi.wvalid & wready_q;
  assign b_hs  = bvalid_q & s_axi.bready;
  assign ar_hs = s_axi.arvalid & arready_q;
  assign r_hs  = rvalid_q & s_axi.rready;

  // A write takes effect once, in the cycle both halves are held and before B is raised.
  assign wr_commit = aw_held_q & w_held_q & ~bvalid_q;
  assign wr_clr    = wr_commit && (32'(widx_q) == 32'd3);
  assign wr_ien    = wr_commit && (32'(widx_q) == 32'd4);
  assign wr_ok     = (32'(widx_q) == 32'd3) || (32'(widx_q) == 32'd4);

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bvalid_d  = bvalid_q;
    if (aw_hs) aw_held_d = 1'b1;
    if (w_hs) w_held_d = 1'b1;
    if (wr_commit) bvalid_d = 1'b1;
    if (b_hs) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      widx_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= ~aw_held_d;
      wready_q  <= ~w_held_d;
      bvalid_q  <= bvalid_d;
      if (aw_hs) widx_q <= s_axi.awaddr[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (wr_commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_DECERR;
    end
  end

  // Event detection, capture and counting; an event overrides a same-cycle clear.
  always_comb begin
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    irq_en_d = irq_en_q;
    nz       = '0;
    ev       = '0;
    load     = '0;
    clr      = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      nz[n]   = |ch_error[n*ERR_W +: ERR_W];
      clr[n]  = wr_clr & wstrb_q[n/8] & wdata_q[n];
      ev[n]   = nz[n] & ~prev_q[n];
      load[n] = ev[n] & (~cap_q[n] | clr[n]);
      if (ev[n]) begin
        cap_d[n] = 1'b1;
        cnt_d[n] = clr[n] ? 32'd1 : sat_inc(cnt_q[n]);
      end else if (clr[n]) begin
        cap_d[n] = 1'b0;
        cnt_d[n] = '0;
      end
      if (wr_ien && wstrb_q[n/8]) irq_en_d[n] = wdata_q[n];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= '0;
      cap_q    <= '0;
      cnt_q    <= '0;
      code_q   <= '0;
      fd_q     <= '0;
      data_q   <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      prev_q   <= nz;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      irq_q    <= |(cap_q & irq_en_q);
      for (int n = 0; n < NUM_CH; n++) begin
        if (load[n]) begin
          code_q[n] <= ch_error[n*ERR_W +: ERR_W];
          data_q[n] <= ch_error_data[n*DATA_W +: DATA_W];
          fd_q[n]   <= ch_expected_fdata[n*32 +: 32];
        end
      end
    end
  end

  // Read decode: globals at 0..5, channel blocks of 32 words from word 64.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    rk      = 0;
    ridx    = 32'(s_axi.araddr[ADDR_W-1:2]);
    rel     = ridx - 32'd64;
    if (ridx < 32'd6) begin
      rd_err = 1'b0;
      case (ridx[2:0])
        3'd0:    rd_data = 32'(ch_status);
        3'd1:    rd_data = 32'(ch_eth_active);
        3'd2:    rd_data = 32'(cap_q);
        3'd3:    rd_data = '0;
        3'd4:    rd_data = 32'(irq_en_q);
        default: rd_data = INFO;
      endcase
    end else if (ridx >= 32'd64) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (rel[31:5] == 27'(n)) begin
          rk = int'(rel[4:0]) - 16;
          if (rel[4:0] == 5'd0) begin
            rd_err  = 1'b0;
            rd_data = 32'(code_q[n]);
          end else if (rel[4:0] == 5'd1) begin
            rd_err  = 1'b0;
            rd_data = fd_q[n];
          end else if (rel[4:0] == 5'd2) begin
            rd_err  = 1'b0;
            rd_data = cnt_q[n];
          end else if (rk >= 0 && rk < NW) begin
            rd_err  = 1'b0;
            rd_data = data_q[n][(NW-1-rk)*32 +: 32];
          end
        end
      end
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    if (ar_hs) rvalid_d = 1'b1;
    if (r_hs) rvalid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= ~rvalid_d;
      rvalid_q  <= rvalid_d;
      if (ar_hs) begin
        rdata_q <= rd_err ? 32'd0 : rd_data;
        rresp_q <= rd_err ? RESP_DECERR : RESP_OKAY;
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_axi_error_reporter_mc.sv
// Scoreboard bench for axi_error_reporter_mc: expected B/R responses are queued
// when a transaction is issued and compared as the DUT hands them over.
module tb_axi_error_reporter_mc;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 512;
  localparam int ERR_W  = 9;
  localparam int ADDR_W = 12;
  localparam logic [31:0] INFO = 32'h1009_0201;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_CH-1:0]        ch_eth_active, ch_status;
  logic [NUM_CH*ERR_W-1:0]  ch_error;
  logic [NUM_CH*DATA_W-1:0] ch_error_data;
  logic [NUM_CH*32-1:0]     ch_expected_fdata;
  logic                     irq;

  axi_error_reporter_mc_if bus();

  axi_error_reporter_mc #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ERR_W(ERR_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ch_eth_active(ch_eth_active),
    .ch_status(ch_status),
    .ch_error(ch_error),
    .ch_error_data(ch_error_data),
    .ch_expected_fdata(ch_expected_fdata),
    .irq(irq),
    .s_axi(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [33:0] v;
  } exp_t;

  exp_t rq[$];
  exp_t bq[$];
  exp_t be, re;
  logic b_hold = 1'b0, r_hold = 1'b0, rand_bp = 1'b0;
  logic [31:0] last_ien;
  logic [31:0] ra[4];
  logic [31:0] rexp[4];
  logic [1:0]  rresp_exp[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    bus.bready = b_hold ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
    bus.rready = r_hold ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) chk("b_extra", 64'd1, 64'd0);
        else begin
          be = bq.pop_front();
          chk(be.tag, 64'(bus.bresp), 64'(be.v[33:32]));
        end
      end
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) chk("r_extra", 64'd1, 64'd0);
        else begin
          re = rq.pop_front();
          chk(re.tag, 64'({bus.rresp, bus.rdata}), 64'(re.v));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [1:0] resp, input string tag, input int aw_dly, input int w_dly);
    exp_t e;
    e.tag = tag;
    e.v   = {resp, 32'd0};
    bq.push_back(e);
    fork
      begin
        bit ok;
        ok = 1'b0;
        if (aw_dly > 0) cyc(aw_dly);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        for (int t = 0; t < 1000 && !ok; t++) begin
          @(negedge clk);
          ok = bus.awready;
        end
        if (!ok) chk({tag, "_aw_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
      end
      begin
        bit ok;
        ok = 1'b0;
        if (w_dly > 0) cyc(w_dly);
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        for (int t = 0; t < 1000 && !ok; t++) begin
          @(negedge clk);
          ok = bus.wready;
        end
        if (!ok) chk({tag, "_w_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.wvalid = 1'b0;
      end
    join
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                    input string tag);
    exp_t e;
    bit ok;
    e.tag = tag;
    e.v   = {resp, data};
    rq.push_back(e);
    ok = 1'b0;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = bus.arready;
    end
    if (!ok) chk({tag, "_ar_timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 2000; t++) begin
      if (rq.size() == 0 && bq.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk({tag, "_pending"}, 64'(rq.size() + bq.size()), 64'd0);
  endtask

  task automatic pulse(input int ch, input logic [ERR_W-1:0] code);
    ch_error[ch*ERR_W +: ERR_W] = code;
    cyc(1);
    ch_error[ch*ERR_W +: ERR_W] = '0;
    cyc(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    ch_status = 2'b10;
    ch_eth_active = 2'b01;
    ch_error = '0;
    ch_error_data = '0;
    ch_expected_fdata = '0;
    ra = '{32'h0, 32'h4, 32'h14, 32'h200};
    rexp = '{32'h2, 32'h1, INFO, 32'h0};
    rresp_exp = '{OKAY, OKAY, OKAY, DECERR};

    // Reset values
    #12;
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("awready_rise", 64'(bus.awready), 64'd1);
    chk("wready_rise", 64'(bus.wready), 64'd1);
    chk("arready_rise", 64'(bus.arready), 64'd1);
    @(posedge clk);
    #1;

    // Reset while a read response is pending
    r_hold = 1'b1;
    cyc(2);
    rd(32'h14, INFO, OKAY, "rd_abandoned");
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.rvalid) break;
    end
    chk("rvalid_pending", 64'(bus.rvalid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_async_arready", 64'(bus.arready), 64'd0);
    rq.delete();
    bq.delete();
    @(negedge clk);
    reset = 1'b0;
    r_hold = 1'b0;
    cyc(2);
    rd(32'h08, 32'h0, OKAY, "rd_captured_rst");
    rd(32'h14, INFO, OKAY, "rd_info");
    rd(32'h00, 32'h2, OKAY, "rd_status");
    rd(32'h04, 32'h1, OKAY, "rd_eth_active");
    rd(32'h0C, 32'h0, OKAY, "rd_clear_reads0");
    chk("irq_after_rst", 64'(irq), 64'd0);
    drain("post_rst");

    // Capture on ch1: snapshot taken on the first cycle, later events only count
    ch_error_data[DATA_W + 480 +: 32] = 32'hDEAD_BEEF;
    ch_error_data[DATA_W + 448 +: 32] = 32'h0BAD_F00D;
    ch_expected_fdata[63:32] = 32'h1234_5678;
    ch_error[ERR_W +: ERR_W] = 9'h05;
    cyc(1);
    ch_error_data[DATA_W + 480 +: 32] = 32'h1111_1111;
    ch_expected_fdata[63:32] = 32'h2222_2222;
    cyc(2);
    ch_error[ERR_W +: ERR_W] = '0;
    cyc(2);
    ch_error[ERR_W +: ERR_W] = 9'h07;
    cyc(1);
    ch_error[ERR_W +: ERR_W] = '0;
    cyc(2);
    rd(32'h180, 32'h5, OKAY, "ch1_code");
    rd(32'h184, 32'h1234_5678, OKAY, "ch1_fdata");
    rd(32'h188, 32'h2, OKAY, "ch1_count");
    rd(32'h1C0, 32'hDEAD_BEEF, OKAY, "ch1_word0");
    rd(32'h1C4, 32'h0BAD_F00D, OKAY, "ch1_word1");
    rd(32'h08, 32'h2, OKAY, "captured_ch1");
    rd(32'h108, 32'h0, OKAY, "ch0_count_idle");
    chk("irq_masked", 64'(irq), 64'd0);
    drain("capture");

    // Interrupt enable then write-1-to-clear
    wr(32'h10, 32'h2, 4'hF, OKAY, "wr_irq_en", 0, 0);
    drain("irq_en");
    cyc(2);
    chk("irq_set", 64'(irq), 64'd1);
    rd(32'h10, 32'h2, OKAY, "rd_irq_en");
    wr(32'h0C, 32'h2, 4'hF, OKAY, "wr_clear_ch1", 0, 0);
    @(negedge clk);
    chk("irq_before_clear", 64'(irq), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("irq_cleared", 64'(irq), 64'd0);
    @(posedge clk);
    #1;
    rd(32'h08, 32'h0, OKAY, "captured_cleared");
    rd(32'h188, 32'h0, OKAY, "ch1_count_cleared");
    drain("clear");

    // Clear colliding with a fresh ch0 event
    ch_expected_fdata[31:0] = 32'hAAAA_0001;
    ch_error_data[480 +: 32] = 32'hCAFE_0001;
    pulse(0, 9'h11);
    pulse(0, 9'h11);
    rd(32'h100, 32'h11, OKAY, "ch0_code_first");
    rd(32'h108, 32'h2, OKAY, "ch0_count_pre");
    drain("pre_collision");
    fork
      wr(32'h0C, 32'h1, 4'hF, OKAY, "wr_clear_collide", 0, 0);
      begin
        cyc(1);
        ch_expected_fdata[31:0] = 32'hBBBB_0002;
        ch_error_data[480 +: 32] = 32'hCAFE_0002;
        ch_error[0 +: ERR_W] = 9'h22;
        cyc(1);
        ch_error[0 +: ERR_W] = '0;
      end
    join
    cyc(2);
    rd(32'h08, 32'h1, OKAY, "collide_captured");
    rd(32'h108, 32'h1, OKAY, "collide_count");
    rd(32'h100, 32'h22, OKAY, "collide_code");
    rd(32'h104, 32'hBBBB_0002, OKAY, "collide_fdata");
    rd(32'h140, 32'hCAFE_0002, OKAY, "collide_word0");
    drain("collision");

    // Counter saturation
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
    cyc(1);
    release dut.cnt_q;
    cyc(1);
    pulse(0, 9'h33);
    pulse(0, 9'h33);
    cyc(1);
    rd(32'h108, 32'hFFFF_FFFF, OKAY, "count_saturated");
    rd(32'h188, 32'h0, OKAY, "ch1_count_untouched");
    drain("saturation");

    // W ahead of AW, held-off BREADY
    b_hold = 1'b1;
    cyc(2);
    fork
      wr(32'h10, 32'h0, 4'hF, OKAY, "wr_w_first", 5, 0);
      begin
        repeat (3) @(negedge clk);
        chk("wready_low_after_hs", 64'(bus.wready), 64'd0);
        chk("awready_waiting", 64'(bus.awready), 64'd1);
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (bus.bvalid) break;
        end
        chk("bvalid_up", 64'(bus.bvalid), 64'd1);
        repeat (4) @(negedge clk);
        chk("bvalid_held", 64'(bus.bvalid), 64'd1);
        chk("awready_blocked", 64'(bus.awready), 64'd0);
        b_hold = 1'b0;
      end
    join
    drain("w_first");
    cyc(3);
    chk("single_b", 64'(bus.bvalid), 64'd0);
    rd(32'h200, 32'h0, DECERR, "rd_ch_out_of_range");
    rd(32'h10C, 32'h0, DECERR, "rd_reserved_offset");
    rd(32'h18, 32'h0, DECERR, "rd_global_unmapped");
    rd(32'h1000_0014, INFO, OKAY, "rd_upper_addr_ignored");
    wr(32'h00, 32'hFF, 4'hF, DECERR, "wr_status_decerr", 0, 0);
    wr(32'h10, 32'h3, 4'h0, OKAY, "wr_no_strobe", 0, 0);
    drain("decerr_writes");
    rd(32'h00, 32'h2, OKAY, "status_unchanged");
    rd(32'h10, 32'h0, OKAY, "irq_en_unchanged");
    drain("protocol");

    // Concurrent traffic under random backpressure
    rand_bp = 1'b1;
    last_ien = '0;
    fork
      for (int i = 0; i < 12; i++) begin
        logic [31:0] v;
        v = 32'($urandom_range(0, 3));
        wr(32'h10, v, 4'hF, OKAY, "wr_rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        last_ien = v;
      end
      for (int i = 0; i < 16; i++) begin
        rd(ra[i % 4], rexp[i % 4], rresp_exp[i % 4], "rd_rand");
        if ($urandom_range(0, 1) == 1) cyc(1);
      end
    join
    drain("random");
    rand_bp = 1'b0;
    cyc(2);
    rd(32'h10, last_ien, OKAY, "irq_en_last");
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_error_reporter_mc.md
Name: axi_error_reporter_mc

Overview:
Parametrised, multi-channel successor to the two-channel error reporter. It contains its own AXI4-Lite slave, so no external slave core is needed. For each checker channel it captures a first-error snapshot (code, data, expected fdata) and keeps a saturating error-event counter. It adds write-1-to-clear and an interrupt output, and sits between the NSDP checker channels and the control-plane AXI interconnect.

Parameters:
NUM_CH, 2, number of checker channels (1..16)
DATA_W, 512, error-data width per channel; multiple of 32, max 512
ERR_W, 9, error-code width per channel (1..32)
ADDR_W, 12, significant AXI byte-address bits; upper bits ignored

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ch_eth_active  in  NUM_CH  per-channel link-active, live
ch_status  in  NUM_CH  per-channel status, live
ch_error  in  NUM_CH*ERR_W  per-channel error code; nonzero = error; channel n at [n*ERR_W +: ERR_W]
ch_error_data  in  NUM_CH*DATA_W  per-channel data beat at error
ch_expected_fdata  in  NUM_CH*32  per-channel expected frame data
irq  out  1  level interrupt
S_AXI_AW{ADDR[31:0],VALID,READY,PROT[2:0]}, S_AXI_W{DATA[31:0],VALID,STRB[3:0],READY}, S_AXI_B{RESP[1:0],VALID,READY}, S_AXI_AR{ADDR[31:0],VALID,PROT[2:0],READY}, S_AXI_R{DATA[31:0],VALID,RESP[1:0],READY}  standard AXI4-Lite slave; PROT ignored

Behaviour:
- Reset (asynchronous, active-high): all READY/VALID = 0, RDATA = 0, RESP = OKAY, irq = 0. Captured flags, snapshots, counters and IRQ_EN = 0. AWREADY, WREADY and ARREADY rise on the first clk after reset deasserts.
- Register index = addr[ADDR_W-1:2]. Global registers:
  - 0 STATUS: ch_status, read-only (RO)
  - 1 ETH_ACTIVE: RO
  - 2 CAPTURED: sticky per-channel flags, RO
  - 3 CLEAR: write-1-to-clear; read returns 0
  - 4 IRQ_EN: bit n enables channel n; read/write
  - 5 INFO: {8'(DATA_W/32), 8'(ERR_W), 8'(NUM_CH), 8'h01}, RO
- Channel n block, base word 64+32n:
  - +0 captured code, zero-extended
  - +1 captured expected fdata
  - +2 event count
  - +16+k, k < DATA_W/32: captured data word; k=0 is the most significant word
- Any other index, including channel n >= NUM_CH and k beyond DATA_W/32: read returns DECERR with RDATA = 0.
- Error event, channel n: ch_error[n] nonzero this cycle and zero the previous cycle (registered prior-nonzero bit).
  - On an event, count increments, saturating at 32'hFFFFFFFF.
  - If CAPTURED[n] = 0 on an event: code, data and fdata are latched from the same cycle and CAPTURED[n] is set.
  - While CAPTURED[n] = 1 the snapshot is frozen; later events only count.
- CLEAR write of bit n clears CAPTURED[n] and count[n]. Only bytes with WSTRB set act.
- CLEAR and event in the same cycle: the event wins. Snapshot takes the new data, CAPTURED = 1, count = 1.
- irq is registered: irq = |(CAPTURED & IRQ_EN), one cycle after the flag changes.
- Write path:
  - AW and W are accepted independently, in any order.
  - Each READY drops after its handshake until BVALID&BREADY completes.
  - BVALID asserts the cycle after both AW and W are held. BRESP = OKAY for CLEAR/IRQ_EN, DECERR otherwise; no state change on DECERR.
  - READYs return the cycle after the B handshake.
- Read path:
  - ARREADY is high when the read path is idle.
  - AR handshake at cycle t gives RVALID at t+1, with RDATA/RRESP held stable until RREADY.
  - ARREADY stays low while RVALID = 1; ARREADY returns the cycle after the R handshake.
- Read and write paths are independent; concurrent operation is legal.
- Reset mid-transaction: the transaction is abandoned, with no B or R response.

Test Plan:
- Reset: assert reset mid-read (RVALID=1) -> RVALID drops asynchronously. After release, CAPTURED reads 0, INFO reads 0x1009_0201 with defaults, irq = 0.
- Capture: ch1 error = 0x05 for 3 cycles with data word15 = 0xDEADBEEF, then 0x07 two cycles later -> ch1 +0 = 0x5; +16 = 0xDEADBEEF; +2 = 2; CAPTURED = 0x2.
- IRQ/clear: IRQ_EN = 0x2, ch1 event -> irq = 1. Write CLEAR = 0x2 -> CAPTURED = 0 and count = 0; irq = 0 one cycle later.
- Collision: CLEAR write lands in the same cycle as a ch0 event -> CAPTURED[0] = 1, count = 1, new snapshot.
- Saturation: force count to 32'hFFFFFFFE (backdoor), then two events -> reads 0xFFFFFFFF.
- Protocol: W before AW with a 5-cycle gap; BREADY low for 4 cycles; read of index 64+32*NUM_CH -> single B = OKAY; RRESP = DECERR with RDATA = 0. Random ready/valid backpressure produces no lost or duplicated responses.
